// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake and FIFO write-port bundle
// shared by the write arbiter and its environment.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_cs;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_cs, fifo_wr_en,
    input  fifo_data_in
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_cs, fifo_wr_en,
    output fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write
// port, with optional burst locking of the grant.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int IDW = (NUM_REQ > 1) ?
                       $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  fifo_wr_arbiter_if.slave     bus,
  output logic [IDW-1:0]       grant_id,
  output logic                 locked,
  output logic [CNT_WIDTH-1:0] wr_count
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                state, state_d;
  logic [IDW-1:0]        rr_ptr, rr_d;
  logic [IDW-1:0]        owner, owner_d;
  logic [IDW-1:0]        win, gnt;
  logic [BW-1:0]         beat_cnt, cnt_d;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  win_ok, gnt_ok;
  logic                  stage_free;
  logic                  accept, wr;

  function automatic logic [IDW-1:0] nxt(
    input logic [IDW-1:0] x
  );
    return (x == IDW'(NUM_REQ - 1)) ?
           '0 : x + 1'b1;
  endfunction

  always_comb begin : scan
    int j;
    j      = 0;
    win    = rr_ptr;
    win_ok = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!win_ok && bus.req_valid[j]) begin
        win    = IDW'(j);
        win_ok = 1'b1;
      end
    end
  end

  assign gnt = (state == LOCK) ? owner : win;
  assign gnt_ok = (state == LOCK) ?
                  bus.req_valid[owner] : win_ok;
  assign stage_free = !out_valid || !bus.fifo_full;
  assign accept = rst_n && en && stage_free && gnt_ok;
  assign wr = out_valid && !bus.fifo_full;

  assign bus.req_ready = accept ?
                         (NUM_REQ'(1) << gnt) : '0;
  assign bus.fifo_cs      = out_valid;
  assign bus.fifo_wr_en   = out_valid;
  assign bus.fifo_data_in = data_q;
  assign locked           = (state == LOCK);

  always_comb begin
    state_d = state;
    rr_d    = rr_ptr;
    owner_d = owner;
    cnt_d   = beat_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (MAX_BURST > 1) begin
            state_d = LOCK;
            owner_d = win;
            cnt_d   = BW'(1);
          end else begin
            rr_d = nxt(win);
          end
        end
      end
      LOCK: begin
        // a vanished owner ends the burst without a beat
        if (!bus.req_valid[owner]) begin
          state_d = IDLE;
          rr_d    = nxt(owner);
        end else if (accept) begin
          cnt_d = beat_cnt + 1'b1;
          if (cnt_d == BW'(MAX_BURST)) begin
            state_d = IDLE;
            rr_d    = nxt(owner);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_d;
      owner    <= owner_d;
      beat_cnt <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_q    <= '0;
      grant_id  <= '0;
      wr_count  <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        data_q    <= bus.req_data[
          int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        grant_id  <= gnt;
      end else if (wr) begin
        out_valid <= 1'b0;
      end
      if (wr) wr_count <= wr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench: per-beat round robin (MAX_BURST=1,
// 4-bit counter) and burst-locked (MAX_BURST=4) arbiters.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b1;
  logic full  = 1'b0;
  logic sel   = 1'b0;
  logic [N-1:0]    vld;
  logic [N*DW-1:0] dat;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) b1();
  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) b4();

  assign b1.req_valid = sel ? '0 : vld;
  assign b4.req_valid = sel ? vld : '0;
  assign b1.req_data  = dat;
  assign b4.req_data  = dat;
  assign b1.fifo_full = full;
  assign b4.fifo_full = full;

  logic [1:0]  gid1, gid4;
  logic        lk1, lk4;
  logic [3:0]  wc1;
  logic [15:0] wc4;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW),
    .MAX_BURST(1), .CNT_WIDTH(4)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(b1),
    .grant_id(gid1), .locked(lk1), .wr_count(wc1)
  );

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW),
    .MAX_BURST(4), .CNT_WIDTH(16)
  ) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .bus(b4),
    .grant_id(gid4), .locked(lk4), .wr_count(wc4)
  );

  wire          wen  = sel ? b4.fifo_wr_en : b1.fifo_wr_en;
  wire [DW-1:0] dout = sel ? b4.fifo_data_in
                           : b1.fifo_data_in;
  wire [N-1:0]  rdy  = sel ? b4.req_ready : b1.req_ready;
  wire [1:0]    gid  = sel ? gid4 : gid1;
  wire          lk   = sel ? lk4 : lk1;
  wire [15:0]   wc   = sel ? wc4 : {12'd0, wc1};

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] d;
    logic        lk;
  } item_t;

  logic [DW-1:0] src [N][16];
  int            head [N];
  int            tail [N];
  item_t         exp_q [$];
  item_t         mit;
  int            n_chk = 0;
  int            n_fail = 0;
  int            wr_model = 0;
  int            wr_base = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic redrive();
    for (int i = 0; i < N; i++) begin
      vld[i] = head[i] < tail[i];
      dat[i*DW +: DW] = (head[i] < tail[i]) ?
                        src[i][head[i]] : '0;
    end
  endtask

  task automatic load(input int p,
                      input logic [31:0] d);
    src[p][tail[p]] = d;
    tail[p]++;
  endtask

  task automatic push(input int p,
                      input logic [31:0] d,
                      input logic l);
    item_t it;
    it.id = 4'(p);
    it.d  = d;
    it.lk = l;
    exp_q.push_back(it);
  endtask

  function automatic bit busy();
    bit b;
    b = 1'b0;
    for (int i = 0; i < N; i++)
      if (head[i] < tail[i]) b = 1'b1;
    return b;
  endfunction

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = vld & rdy & {N{rst_n}};
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) head[i]++;
    redrive();
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    exp_q.delete();
    wr_base = wr_model;
    redrive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy()) && n < 100) begin
      step();
      n++;
    end
    chk("drain_left", 64'(exp_q.size()), 0);
  endtask

  // FIFO-side monitor: a write happens at the coming edge
  always @(negedge clk) begin
    if (rst_n && wen && !full) begin
      if (exp_q.size() == 0) begin
        chk("extra_wr", 1, 0);
      end else begin
        mit = exp_q.pop_front();
        chk("data", dout, mit.d);
        chk("gid", gid, mit.id);
        chk("lock", lk, mit.lk);
      end
      wr_model++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    vld = '0;
    dat = '0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    load(0, 32'h5);
    redrive();
    #3;
    chk("rst_rdy", b1.req_ready, 0);
    do_reset();
    chk("rst_wen", b1.fifo_wr_en, 0);
    chk("rst_cnt", wc1, 0);
    chk("rst_gid", gid1, 0);
    chk("rst_lk4", lk4, 0);
    chk("rst_dat4", b4.fifo_data_in, 0);

    // single producer, per-beat arbiter
    send1();
    drain();
    chk("t1_cnt", wc, 3);
    chk("t1_model", wc, 16'(wr_model - wr_base));
    chk("t1_gid", gid, 0);

    // four producers, strict rotation, 4-bit wrap
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < N; i++) begin
        load(i, 32'(i*16 + k));
        push(i, 32'(i*16 + k), 1'b0);
      end
    redrive();
    drain();
    chk("t2_wrap", wc, 0);
    chk("t2_n", 64'(wr_model - wr_base), 16);

    // burst locking on producers 0 and 2
    sel = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) load(0, 32'(8'hA0 + k));
    for (int k = 0; k < 4; k++) load(2, 32'(8'hC0 + k));
    for (int k = 0; k < 4; k++)
      push(0, 32'(8'hA0 + k), k != 3);
    for (int k = 0; k < 4; k++)
      push(2, 32'(8'hC0 + k), k != 3);
    for (int k = 4; k < 8; k++)
      push(0, 32'(8'hA0 + k), k != 7);
    redrive();
    step();
    chk("t3_lk", lk, 1);
    drain();
    chk("t3_cnt", wc, 12);

    // back-pressure while the stage is occupied
    for (int k = 1; k <= 3; k++) begin
      load(1, 32'(8'h50 + k));
      push(1, 32'(8'h50 + k), 1'b1);
    end
    redrive();
    step();
    full = 1'b1;
    repeat (5) begin
      step();
      chk("bp_rdy", rdy, 0);
      chk("bp_data", dout, 32'h51);
      chk("bp_cnt", wc, 12);
    end
    full = 1'b0;
    drain();
    chk("bp_cnt2", wc, 15);

    // early unlock: owner 3 leaves, rotation goes to 0
    load(3, 32'h31); push(3, 32'h31, 1'b1);
    load(3, 32'h32); push(3, 32'h32, 1'b1);
    load(0, 32'h01); push(0, 32'h01, 1'b1);
    load(0, 32'h02); push(0, 32'h02, 1'b1);
    load(1, 32'h11); push(1, 32'h11, 1'b1);
    redrive();
    drain();
    chk("eu_cnt", wc, 20);

    // en low: pending beat drains, no new grants
    load(2, 32'h21); push(2, 32'h21, 1'b1);
    load(2, 32'h22); push(2, 32'h22, 1'b1);
    redrive();
    step();
    en = 1'b0;
    repeat (3) begin
      step();
      chk("en_rdy", rdy, 0);
      chk("en_lk", lk, 1);
    end
    chk("en_wr", wc, 21);
    en = 1'b1;
    drain();
    chk("en_cnt", wc, 22);

    // asynchronous reset in the middle of a burst
    for (int k = 0; k < 4; k++) load(0, 32'(8'hE0 + k));
    push(0, 32'hE0, 1'b1);
    redrive();
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_wen", wen, 0);
    chk("ar_cnt", wc, 0);
    chk("ar_lk", lk, 0);
    chk("ar_rdy", rdy, 0);
    chk("ar_q", 64'(exp_q.size()), 0);
    flush();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    load(2, 32'h2A);
    load(0, 32'h0A);
    push(0, 32'h0A, 1'b1);
    push(2, 32'h2A, 1'b1);
    redrive();
    drain();
    chk("ar_cnt2", wc, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  task automatic send1();
    load(0, 32'd1);   push(0, 32'd1, 1'b0);
    load(0, 32'd10);  push(0, 32'd10, 1'b0);
    load(0, 32'd100); push(0, 32'd100, 1'b0);
    redrive();
    chk("lat_pre", wen, 0);
    step();
    chk("lat_wen", wen, 1);
    chk("lat_data", dout, 1);
  endtask

endmodule
